// File: rtl/muxn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muxn_pkg                                                   |
// | Purpose : Shared definitions for the N-channel stream multiplexer:   |
// |           selection-mode constants, the holding-register state type |
// |           and a ceil(log2) helper used to size channel indices.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package muxn_pkg;

  localparam int MODE_SEL = 0;  // explicit select input chooses the channel
  localparam int MODE_RR  = 1;  // round-robin among valid channels

  // Output holding register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_t;

  // Index width for n channels; never narrower than one bit
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arb                                                     |
// | Purpose : N-way round-robin priority picker. The search for a        |
// |           requester starts one past the last granted index and       |
// |           wraps. The last-granted index is held here and advances    |
// |           only on an update strobe.                                  |
// | Ports   : clk, rst_n        clock, async active-low reset            |
// |           i_req[N]          request vector                           |
// |           i_update          a transfer on the current grant happened |
// |           o_grant[SELW]     granted index                            |
// |           o_gnt_valid       at least one request present             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_arb
  import muxn_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_req,
  input  logic            i_update,
  output logic [SELW-1:0] o_grant,
  output logic            o_gnt_valid
);

  logic [SELW-1:0] r_last;
  logic [SELW-1:0] w_idx;

  // Walk offsets from farthest to nearest so the requester closest after
  // r_last is the one left standing.
  always_comb begin
    o_grant     = '0;
    o_gnt_valid = 1'b0;
    w_idx       = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = SELW'((int'(r_last) + k) % N);
      if (i_req[w_idx]) begin
        o_grant     = w_idx;
        o_gnt_valid = 1'b1;
      end
    end
  end

  // Reset to N-1 so the first search after reset begins at channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= SELW'(N - 1);
    end else if (i_update && o_gnt_valid) begin
      r_last <= o_grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muxn_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muxn_stream                                                |
// | Purpose : N-channel WIDTH-bit stream multiplexer with a registered   |
// |           output word and valid/ready handshakes on every channel.   |
// |           Channel selection is by explicit select (MODE_SEL) or      |
// |           round-robin among valid channels (MODE_RR).                |
// | Ports   : CLK, RST_N        clock, async active-low reset            |
// |           D[N*WIDTH]        channel i data at [i*WIDTH +: WIDTH]     |
// |           V[N] / R[N]       channel valid / ready (R combinational)  |
// |           S[SELW]           channel select, MODE_SEL only            |
// |           Y[WIDTH], YV, YS  registered data, valid, source index     |
// |           YR                consumer ready                           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module muxn_stream
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SELW  = clog2(N)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N*WIDTH-1:0] D,
  input  logic [N-1:0]       V,
  output logic [N-1:0]       R,
  input  logic [SELW-1:0]    S,
  output logic [WIDTH-1:0]   Y,
  output logic               YV,
  input  logic               YR,
  output logic [SELW-1:0]    YS
);

  hold_state_t      r_state;
  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_ys;

  logic             w_accept;
  logic             w_gnt_valid;
  logic             w_xfer;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_data;

  assign YV = (r_state == ST_FULL);
  assign Y  = r_y;
  assign YS = r_ys;

  // Holding register can take a word when empty or being drained now
  assign w_accept = !YV || YR;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic w_unused_sel;
      assign w_unused_sel = ^S;

      rr_arb #(
        .N    (N),
        .SELW (SELW)
      ) u_rr_arb (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_req       (V),
        .i_update    (w_xfer),
        .o_grant     (w_grant),
        .o_gnt_valid (w_gnt_valid)
      );
    end else begin : g_sel
      // Compare against every legal index so an S beyond N-1 (non power
      // of two N) simply never matches.
      always_comb begin
        w_gnt_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (S == SELW'(i) && V[i]) begin
            w_gnt_valid = 1'b1;
          end
        end
      end
      assign w_grant = S;
    end
  endgenerate

  // Data steering and one-hot ready. R is gated by RST_N so no channel
  // sees ready while reset is held.
  always_comb begin
    w_data = '0;
    R      = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_data = D[i*WIDTH +: WIDTH];
        R[i]   = RST_N && w_accept && w_gnt_valid;
      end
    end
  end

  assign w_xfer = |(V & R);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
      r_ys    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) begin
            r_y     <= w_data;
            r_ys    <= w_grant;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A simultaneous drain and load keeps the register full
          if (w_xfer) begin
            r_y     <= w_data;
            r_ys    <= w_grant;
          end else if (YR) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muxn_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_muxn_stream                                             |
// | Purpose : Self-checking bench for muxn_stream. Three instances:      |
// |           explicit select N=4, explicit select N=3, round-robin N=4, |
// |           each compared every cycle against a behavioural model.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_muxn_stream;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] tb_d  [NDUT];
  logic [3:0]  tb_v  [NDUT];
  logic [1:0]  tb_s  [NDUT];
  logic        tb_yr [NDUT];

  logic [3:0] r0;  logic [7:0] y0;  logic yv0;  logic [1:0] ys0;
  logic [2:0] r1;  logic [7:0] y1;  logic yv1;  logic [1:0] ys1;
  logic [3:0] r2;  logic [7:0] y2;  logic yv2;  logic [1:0] ys2;

  muxn_stream #(.WIDTH(8), .N(4), .MODE(0)) u_sel4 (
    .CLK(clk), .RST_N(rst_n), .D(tb_d[0]), .V(tb_v[0]), .R(r0), .S(tb_s[0]),
    .Y(y0), .YV(yv0), .YR(tb_yr[0]), .YS(ys0));

  muxn_stream #(.WIDTH(8), .N(3), .MODE(0)) u_sel3 (
    .CLK(clk), .RST_N(rst_n), .D(tb_d[1][23:0]), .V(tb_v[1][2:0]), .R(r1), .S(tb_s[1]),
    .Y(y1), .YV(yv1), .YR(tb_yr[1]), .YS(ys1));

  muxn_stream #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
    .CLK(clk), .RST_N(rst_n), .D(tb_d[2]), .V(tb_v[2]), .R(r2), .S(tb_s[2]),
    .Y(y2), .YV(yv2), .YR(tb_yr[2]), .YS(ys2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_y    [NDUT];
  int         m_ys   [NDUT];
  logic       m_yv   [NDUT];
  int         m_last [NDUT];

  function automatic int nch(input int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int is_rr(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  // Channel that would be granted now, or -1
  function automatic int ref_grant(input int k);
    int n;
    int s;
    int idx;
    n = nch(k);
    if (is_rr(k) == 0) begin
      s = int'(tb_s[k]);
      if (s < n && tb_v[k][s]) return s;
      return -1;
    end
    for (int j = 1; j <= n; j++) begin
      idx = (m_last[k] + j) % n;
      if (tb_v[k][idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_r(input int k);
    int g;
    g = ref_grant(k);
    if (rst_n && (!m_yv[k] || tb_yr[k]) && g >= 0) return 4'(1 << g);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_y[k]    = 8'h00;
      m_ys[k]   = 0;
      m_yv[k]   = 1'b0;
      m_last[k] = nch(k) - 1;
    end
  endtask

  task automatic model_edge(input int k);
    int g;
    if (!rst_n) begin
      m_y[k] = 8'h00; m_ys[k] = 0; m_yv[k] = 1'b0; m_last[k] = nch(k) - 1;
    end else begin
      g = ref_grant(k);
      if ((!m_yv[k] || tb_yr[k]) && g >= 0) begin
        m_y[k]    = tb_d[k][g*8 +: 8];
        m_ys[k]   = g;
        m_yv[k]   = 1'b1;
        m_last[k] = g;
      end else if (m_yv[k] && tb_yr[k]) begin
        m_yv[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] get_r(input int k);
    case (k)
      0:       return {28'd0, r0};
      1:       return {29'd0, r1};
      default: return {28'd0, r2};
    endcase
  endfunction

  function automatic logic [31:0] get_y(input int k);
    case (k)
      0:       return {24'd0, y0};
      1:       return {24'd0, y1};
      default: return {24'd0, y2};
    endcase
  endfunction

  function automatic logic [31:0] get_yv(input int k);
    case (k)
      0:       return {31'd0, yv0};
      1:       return {31'd0, yv1};
      default: return {31'd0, yv2};
    endcase
  endfunction

  function automatic logic [31:0] get_ys(input int k);
    case (k)
      0:       return {30'd0, ys0};
      1:       return {30'd0, ys1};
      default: return {30'd0, ys2};
    endcase
  endfunction

  // Called at a falling edge with inputs already driven: checks ready,
  // crosses one rising edge, then checks the registered outputs.
  task automatic step();
    #1;
    for (int k = 0; k < NDUT; k++) check($sformatf("R[%0d]", k), get_r(k), {28'd0, exp_r(k)});
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("Y[%0d]", k),  get_y(k),  {24'd0, m_y[k]});
      check($sformatf("YV[%0d]", k), get_yv(k), {31'd0, m_yv[k]});
      check($sformatf("YS[%0d]", k), get_ys(k), 32'(m_ys[k]));
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once
  task automatic reset_pulse();
    for (int k = 0; k < NDUT; k++) tb_v[k] = 4'h0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("arst_Y[%0d]", k),  get_y(k),  32'h0);
      check($sformatf("arst_YV[%0d]", k), get_yv(k), 32'h0);
      check($sformatf("arst_YS[%0d]", k), get_ys(k), 32'h0);
      check($sformatf("arst_R[%0d]", k),  get_r(k),  32'h0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rr_a[6];
    int rr_b[4];
    int rr_c[3];
    rr_a = '{0, 1, 2, 3, 0, 1};
    rr_b = '{3, 1, 3, 1};
    rr_c = '{0, 3, 0};

    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      tb_d[k] = '0; tb_v[k] = '0; tb_s[k] = '0; tb_yr[k] = 1'b1;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_Y[%0d]", k),  get_y(k),  32'h0);
      check($sformatf("rst_YV[%0d]", k), get_yv(k), 32'h0);
      check($sformatf("rst_YS[%0d]", k), get_ys(k), 32'h0);
    end
    tb_v[0] = 4'b0001;
    #1 check("rst_R_held", get_r(0), 32'h0);
    tb_v[0] = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Explicit select: single word in, then drained
    tb_s[0] = 2'd2; tb_v[0] = 4'b0100; tb_d[0] = 32'h00A5_0000;
    #1 check("sel_R", get_r(0), 32'h4);
    step();
    check("sel_Y", get_y(0), 32'hA5);
    check("sel_YV", get_yv(0), 32'h1);
    check("sel_YS", get_ys(0), 32'h2);
    tb_v[0] = 4'b0000;
    step();
    check("sel_drain_YV", get_yv(0), 32'h0);
    check("sel_drain_Y", get_y(0), 32'hA5);

    // N=3 with out-of-range select never grants
    tb_s[1] = 2'd3; tb_v[1] = 4'b0111; tb_d[1] = 32'h0077_6655;
    repeat (5) begin
      step();
      check("n3_R", get_r(1), 32'h0);
      check("n3_YV", get_yv(1), 32'h0);
    end
    tb_v[1] = 4'b0000;

    // Backpressure: held word stays while YR low
    tb_s[0] = 2'd1; tb_v[0] = 4'b0010; tb_d[0] = 32'h0000_1100; tb_yr[0] = 1'b1;
    step();
    check("bp_fill", get_y(0), 32'h11);
    tb_yr[0] = 1'b0; tb_d[0] = 32'h0000_2200;
    repeat (10) begin
      step();
      check("bp_R", get_r(0), 32'h0);
      check("bp_Y", get_y(0), 32'h11);
      check("bp_YV", get_yv(0), 32'h1);
    end
    tb_yr[0] = 1'b1;
    step();
    check("bp_release_Y", get_y(0), 32'h22);
    check("bp_release_YS", get_ys(0), 32'h1);
    check("bp_release_YV", get_yv(0), 32'h1);

    // Reset while full
    reset_pulse();

    // Round-robin fairness
    tb_v[2] = 4'b1111; tb_yr[2] = 1'b1; tb_d[2] = 32'h4433_2211;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_all_YS", get_ys(2), 32'(rr_a[i]));
    end
    tb_v[2] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_alt_YS", get_ys(2), 32'(rr_b[i]));
    end

    // Round-robin pointer returns to the start after reset
    tb_v[2] = 4'b0100;
    step();
    check("rr_last2", get_ys(2), 32'h2);
    reset_pulse();
    tb_v[2] = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_post_rst_YS", get_ys(2), 32'(rr_c[i]));
    end

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        tb_d[k]  = $urandom;
        tb_v[k]  = 4'($urandom);
        tb_s[k]  = 2'($urandom);
        tb_yr[k] = ($urandom_range(0, 3) != 0);
      end
      rst_n = ($urandom_range(0, 49) != 0);
      if (!rst_n) model_reset();
      step();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
